ysyx_22050019_div_issue: RTL and testbench

//  Issue/collect controller between EXU decode and ysyx_22050019_divider for RV64M div/rem ops.

---
 rtl/ysyx_22050019_div_issue_if.sv | 49 ++++
 rtl/ysyx_22050019_div_issue.sv | 130 +++++++++++++
 tb/tb_ysyx_22050019_div_issue.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_div_issue_if.sv
// Handshake bundle between decode, the divider and writeback.
// master = the issue controller, slave = its environment.
interface ysyx_22050019_div_issue_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic             in_word;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;

  logic             div_valid;
  logic [7:0]       div_type;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic             div_result_ready;
  logic [XLEN-1:0]  div_out;
  logic             div_result_ok;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    input  in_valid, in_funct3, in_word,
    input  in_src1, in_src2, in_tag, flush,
    input  div_out, div_result_ok, out_ready,
    output in_ready, div_valid, div_type,
    output div_dividend, div_divisor,
    output div_result_ready,
    output out_valid, out_data, out_tag, busy
  );

  modport slave (
    output in_valid, in_funct3, in_word,
    output in_src1, in_src2, in_tag, flush,
    output div_out, div_result_ok, out_ready,
    input  in_ready, div_valid, div_type,
    input  div_dividend, div_divisor,
    input  div_result_ready,
    input  out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/ysyx_22050019_div_issue.sv
// Issue/collect controller for RV64M div/rem ops in front of
// the iterative divider; drains and drops results of flushed ops.
module ysyx_22050019_div_issue #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst_n,
  ysyx_22050019_div_issue_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic             r_kill;
  logic             r_in_ready;
  logic             r_div_valid;
  logic [7:0]       r_div_type;
  logic [XLEN-1:0]  r_dividend;
  logic [XLEN-1:0]  r_divisor;
  logic             r_res_ready;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_busy;

  logic [7:0]       w_type;
  logic             w_accept;

  always_comb begin
    w_type = 8'h00;
    unique case ({bus.in_word, bus.in_funct3[1:0]})
      3'b000: w_type = 8'h08;
      3'b001: w_type = 8'h04;
      3'b010: w_type = 8'h80;
      3'b011: w_type = 8'h40;
      3'b100: w_type = 8'h01;
      3'b101: w_type = 8'h02;
      3'b110: w_type = 8'h10;
      3'b111: w_type = 8'h20;
    endcase
  end

  assign w_accept = bus.in_valid
                  & bus.in_funct3[2]
                  & ~bus.flush;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_kill      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_div_valid <= 1'b0;
      r_div_type  <= 8'h00;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_res_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_ISSUE;
            r_kill      <= 1'b0;
            r_div_type  <= w_type;
            r_dividend  <= bus.in_src1;
            r_divisor   <= bus.in_src2;
            r_out_tag   <= bus.in_tag;
            r_in_ready  <= 1'b0;
            r_div_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state     <= S_WAIT;
          r_div_valid <= 1'b0;
          r_res_ready <= 1'b1;
          if (bus.flush) r_kill <= 1'b1;
        end
        S_WAIT: begin
          // The divider cannot abort: a killed op is drained here.
          if (bus.div_result_ok) begin
            r_res_ready <= 1'b0;
            if (r_kill || bus.flush) begin
              r_kill     <= 1'b0;
              r_state    <= S_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_out_data  <= bus.div_out;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end else if (bus.flush) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready || bus.flush) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.div_valid        = r_div_valid;
  assign bus.div_type         = r_div_type;
  assign bus.div_dividend     = r_dividend;
  assign bus.div_divisor      = r_divisor;
  assign bus.div_result_ready = r_res_ready;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_data         = r_out_data;
  assign bus.out_tag          = r_out_tag;
  assign bus.busy             = r_busy;

endmodule

// File: tb/tb_ysyx_22050019_div_issue.sv
// Scoreboard bench for the div issue controller with a
// behavioural divider responder and RISC-V reference model.
module tb_ysyx_22050019_div_issue;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050019_div_issue_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

  ysyx_22050019_div_issue #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] d;
    logic [4:0]  t;
  } out_t;

  typedef struct {
    logic [7:0]  ty;
    logic [63:0] a;
    logic [63:0] b;
  } iss_t;

  out_t oq[$];
  iss_t iq[$];
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  bit long_lat = 1'b0;
  int n_outv = 0;
  int n_drain = 0;
  int n_issued = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s (bound expired or unexpected event)", nm);
  endtask

  function automatic logic [7:0] map_type(bit w, logic [1:0] f);
    case ({w, f})
      3'b000:  return 8'h08;
      3'b001:  return 8'h04;
      3'b010:  return 8'h80;
      3'b011:  return 8'h40;
      3'b100:  return 8'h01;
      3'b101:  return 8'h02;
      3'b110:  return 8'h10;
      default: return 8'h20;
    endcase
  endfunction

  function automatic bit is_exc(logic [1:0] f, bit w,
                                logic [63:0] a, logic [63:0] b);
    if (w) begin
      if (b[31:0] == 32'd0) return 1'b1;
      return !f[0] && a[31:0] == 32'h8000_0000
             && b[31:0] == 32'hFFFF_FFFF;
    end
    if (b == 64'd0) return 1'b1;
    return !f[0] && a == 64'h8000_0000_0000_0000 && b == '1;
  endfunction

  // RISC-V M semantics: f = funct3[1:0] (div, divu, rem, remu).
  function automatic logic [63:0] ref_div(logic [1:0] f, bit w,
                                          logic [63:0] a, logic [63:0] b);
    logic signed [31:0] sa32, sb32, q32;
    logic signed [63:0] sa, sb, q;
    logic [31:0] r32;
    logic [63:0] r;
    bit ovf;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      ovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
      case (f)
        2'd0: if (b[31:0] == 0) r32 = '1;
              else if (ovf) r32 = 32'h8000_0000;
              else begin q32 = sa32 / sb32; r32 = q32; end
        2'd1: if (b[31:0] == 0) r32 = '1;
              else r32 = a[31:0] / b[31:0];
        2'd2: if (b[31:0] == 0) r32 = a[31:0];
              else if (ovf) r32 = 32'd0;
              else begin q32 = sa32 % sb32; r32 = q32; end
        default: if (b[31:0] == 0) r32 = a[31:0];
                 else r32 = a[31:0] % b[31:0];
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = a;
    sb = b;
    ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
    case (f)
      2'd0: if (b == 0) r = '1;
            else if (ovf) r = a;
            else begin q = sa / sb; r = q; end
      2'd1: if (b == 0) r = '1;
            else r = a / b;
      2'd2: if (b == 0) r = a;
            else if (ovf) r = 64'd0;
            else begin q = sa % sb; r = q; end
      default: if (b == 0) r = a;
               else r = a % b;
    endcase
    return r;
  endfunction

  // Behavioural divider: fixed T+2 answer on exceptions, else variable.
  initial begin : divider
    logic [7:0]  ty;
    logic [63:0] a, b, res;
    logic [1:0]  f;
    bit w, known, hs;
    int lat, g;
    bus.div_result_ok = 1'b0;
    bus.div_out = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.div_valid) begin
        ty = bus.div_type;
        a = bus.div_dividend;
        b = bus.div_divisor;
        known = 1'b1;
        case (ty)
          8'h08: begin f = 2'd0; w = 1'b0; end
          8'h04: begin f = 2'd1; w = 1'b0; end
          8'h80: begin f = 2'd2; w = 1'b0; end
          8'h40: begin f = 2'd3; w = 1'b0; end
          8'h01: begin f = 2'd0; w = 1'b1; end
          8'h02: begin f = 2'd1; w = 1'b1; end
          8'h10: begin f = 2'd2; w = 1'b1; end
          8'h20: begin f = 2'd3; w = 1'b1; end
          default: begin f = 2'd0; w = 1'b0; known = 1'b0; end
        endcase
        res = known ? ref_div(f, w, a, b) : 64'hBAD0_BAD0_BAD0_BAD0;
        if (known && is_exc(f, w, a, b)) lat = 1;
        else if (long_lat) lat = 40;
        else lat = $urandom_range(2, 9);
        repeat (lat) @(posedge clk);
        #1;
        bus.div_result_ok = 1'b1;
        bus.div_out = res;
        hs = 1'b0;
        g = 0;
        while (!hs && g < 200) begin
          @(negedge clk);
          hs = bus.div_result_ready;
          @(posedge clk);
          g++;
        end
        #1;
        bus.div_result_ok = 1'b0;
        bus.div_out = '0;
        if (!hs) fail("div_result_ready_timeout");
        n_drain++;
      end
    end
  end

  initial begin : rdy_drv
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    iss_t e;
    out_t o;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.div_valid) begin
          if (iq.size() == 0) fail("unexpected_div_valid");
          else begin
            e = iq.pop_front();
            chk("div_type", {56'd0, bus.div_type}, {56'd0, e.ty});
            chk("div_dividend", bus.div_dividend, e.a);
            chk("div_divisor", bus.div_divisor, e.b);
          end
        end
        if (bus.out_valid) n_outv++;
        if (bus.out_valid && bus.out_ready) begin
          if (oq.size() == 0) fail("unexpected_out_valid");
          else begin
            o = oq.pop_front();
            chk("out_data", bus.out_data, o.d);
            chk("out_tag", {59'd0, bus.out_tag}, {59'd0, o.t});
          end
        end
      end
    end
  end

  task automatic send(logic [2:0] f3, bit w, logic [63:0] a,
                      logic [63:0] b, logic [4:0] tag,
                      logic [63:0] exp, bit kill);
    int g = 0;
    iss_t e;
    out_t o;
    @(negedge clk);
    while (!bus.in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) fail("in_ready_timeout");
    bus.in_valid = 1'b1;
    bus.in_funct3 = f3;
    bus.in_word = w;
    bus.in_src1 = a;
    bus.in_src2 = b;
    bus.in_tag = tag;
    e.ty = map_type(w, f3[1:0]);
    e.a = a;
    e.b = b;
    iq.push_back(e);
    n_issued++;
    if (!kill) begin
      o.d = exp;
      o.t = tag;
      oq.push_back(o);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_src1 = {$urandom, $urandom};
    bus.in_src2 = {$urandom, $urandom};
  endtask

  task automatic wait_idle(string nm, int lim);
    int g = 0;
    @(negedge clk);
    while ((bus.busy || oq.size() != 0 || iq.size() != 0) && g < lim) begin
      @(negedge clk);
      g++;
    end
    if (g >= lim) fail(nm);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    logic [63:0] a, b, e;
    logic [2:0] f3;
    bit w;
    int nv, nd;
    bus.in_valid = 1'b0;
    bus.in_funct3 = 3'd0;
    bus.in_word = 1'b0;
    bus.in_src1 = '0;
    bus.in_src2 = '0;
    bus.in_tag = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_div_valid", {63'd0, bus.div_valid}, 64'd0);
    chk("rst_div_type", {56'd0, bus.div_type}, 64'd0);
    chk("rst_dividend", bus.div_dividend, 64'd0);
    chk("rst_divisor", bus.div_divisor, 64'd0);
    chk("rst_res_ready", {63'd0, bus.div_result_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);

    send(3'b101, 1'b0, 64'd100, 64'd7, 5'd3, 64'd14, 1'b0);
    @(negedge clk);
    chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    chk("in_ready_after_accept", {63'd0, bus.in_ready}, 64'd0);
    wait_idle("idle_divu", 300);
    chk("busy_after_done", {63'd0, bus.busy}, 64'd0);

    send(3'b110, 1'b0, -64'sd7, 64'd2, 5'd4, '1, 1'b0);
    send(3'b100, 1'b0, 64'd12345, 64'd0, 5'd5, '1, 1'b0);
    send(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
         5'd6, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(3'b101, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd4, 5'd7,
         64'd4, 1'b0);
    send(3'b111, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd8,
         64'hFFFF_FFFF_9ABC_DEF0, 1'b0);
    wait_idle("idle_directed", 600);

    // Writeback stalls: result must hold steady.
    rdy_mode = 1;
    e = ref_div(2'd0, 1'b0, 64'd1000, 64'd9);
    send(3'b100, 1'b0, 64'd1000, 64'd9, 5'd9, e, 1'b0);
    nv = 0;
    while (!bus.out_valid && nv < 100) begin
      @(negedge clk);
      nv++;
    end
    if (!bus.out_valid) fail("hold_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_data", bus.out_data, 64'd111);
      chk("hold_tag", {59'd0, bus.out_tag}, 64'd9);
      @(negedge clk);
    end
    rdy_mode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_hold", {63'd0, bus.in_ready}, 64'd1);
    chk("out_valid_after_hold", {63'd0, bus.out_valid}, 64'd0);
    rdy_mode = 0;

    // Flush 10 cycles into WAIT: result drained, nothing written back.
    long_lat = 1'b1;
    nv = n_outv;
    nd = n_drain;
    send(3'b101, 1'b0, 64'd999, 64'd10, 5'd10, 64'd0, 1'b1);
    @(negedge clk);
    long_lat = 1'b0;
    repeat (11) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    wait_idle("idle_flush_wait", 200);
    chk("flush_wait_no_out", n_outv, nv);
    chk("flush_wait_drained", n_drain, nd + 1);
    send(3'b111, 1'b0, 64'd999, 64'd10, 5'd11, 64'd9, 1'b0);
    wait_idle("idle_after_flush", 200);

    // Flush during the issue pulse.
    nv = n_outv;
    send(3'b110, 1'b1, 64'd77, 64'd5, 5'd12, 64'd0, 1'b1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    wait_idle("idle_flush_issue", 200);
    chk("flush_issue_no_out", n_outv, nv);

    // Flush in IDLE, and a non-div funct3, are both ignored.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_funct3 = 3'b100;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_funct3 = 3'b001;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ignored_busy", {63'd0, bus.busy}, 64'd0);
    chk("ignored_in_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 40; i++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 63);
      case ($urandom_range(0, 5))
        0:       b = 64'd0;
        1:       b = '1;
        2:       b = 64'($urandom_range(1, 20));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 62);
      endcase
      if (i == 7) begin
        a = 64'h8000_0000_0000_0000;
        b = '1;
        f3 = 3'b100;
        w = 1'b0;
      end
      send(f3, w, a, b, 5'($urandom), ref_div(f3[1:0], w, a, b), 1'b0);
    end
    wait_idle("idle_random", 2000);
    chk("all_drained", n_drain, n_issued);
    chk("final_in_ready", {63'd0, bus.in_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
